wave_rom_sequencer: RTL

WAVE_ROM_SEQUENCER -- requirements
Module: wave_rom_sequencer

---
 rtl/wave_seq_pkg.sv | 17 +
 rtl/wave_seq_pipe.sv | 32 +++
 rtl/wave_rom_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the wavetable sequencer: FSM states,
// default widths and the DAC midscale code.
package wave_seq_pkg;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_PHASE_WIDTH = 32;
  localparam int DEF_ROM_LATENCY = 1;

  localparam logic [DEF_DATA_WIDTH-1:0] MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2,
    FLUSH    = 2'd3
  } seq_state_t;
endpackage

// File: rtl/wave_seq_pipe.sv
// Delay line that aligns the sample-valid and period-start flags with the
// ROM read data, LATENCY cycles after the address was issued.
module wave_seq_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_period,
  output logic out_valid,
  output logic out_period
);
  logic [LATENCY-1:0] valid_sr;
  logic [LATENCY-1:0] period_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr  <= '0;
      period_sr <= '0;
    end else begin
      valid_sr[0]  <= in_valid;
      period_sr[0] <= in_period;
      for (int i = 1; i < LATENCY; i++) begin
        valid_sr[i]  <= valid_sr[i-1];
        period_sr[i] <= period_sr[i-1];
      end
    end
  end

  assign out_valid  = valid_sr[LATENCY-1];
  assign out_period = period_sr[LATENCY-1];
endmodule

// File: rtl/wave_rom_sequencer.sv
// DDS-style wavetable sequencer: a phase accumulator addresses an external
// ROM and the returned samples are forwarded to a DAC with matching flags.
module wave_rom_sequencer
  import wave_seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int ROM_LATENCY = DEF_ROM_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_fword,
  input  logic [ADDR_WIDTH-1:0]  cfg_poff,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_rddata,
  output logic [DATA_WIDTH-1:0]  dac_data,
  output logic                   dac_valid,
  output logic                   period_start
);
  localparam logic [DATA_WIDTH-1:0] MID_SAMPLE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

  seq_state_t state, state_next;
  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] active_fword, shadow_fword;
  logic [ADDR_WIDTH-1:0]  active_poff, shadow_poff;
  logic                   pending;
  logic [CNT_W-1:0]       flush_cnt;
  logic [PHASE_WIDTH:0]   sum_full;
  logic                   wrap;
  logic                   issue;
  logic                   ready_int;
  logic                   handshake;

  assign sum_full  = {1'b0, acc} + {1'b0, active_fword};
  assign wrap      = sum_full[PHASE_WIDTH];
  assign handshake = cfg_valid && ready_int;
  assign rom_addr  = acc[PHASE_WIDTH-1 -: ADDR_WIDTH] + active_poff;
  assign busy      = (state != IDLE);
  // Ready stays low while reset is held, even though the state already reads IDLE.
  assign cfg_ready = rst_n && ready_int;

  always_comb begin
    state_next = state;
    ready_int  = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        ready_int = 1'b1;
        if (start && !stop) state_next = RUN;
      end
      RUN: begin
        issue     = 1'b1;
        ready_int = !pending;
        if (stop) state_next = STOPPING;
      end
      STOPPING: begin
        issue = 1'b1;
        // A zero tuning word never wraps, so stop immediately instead.
        if (wrap || (active_fword == '0)) state_next = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == CNT_W'(ROM_LATENCY - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      active_fword <= '0;
      active_poff  <= '0;
      shadow_fword <= '0;
      shadow_poff  <= '0;
      pending      <= 1'b0;
      flush_cnt    <= '0;
    end else begin
      state <= state_next;

      if (issue && (state_next != FLUSH)) acc <= sum_full[PHASE_WIDTH-1:0];
      else                                acc <= '0;

      if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      else                flush_cnt <= '0;

      if (state == IDLE && handshake) begin
        active_fword <= cfg_fword;
        active_poff  <= cfg_poff;
      end else if (state == RUN) begin
        if (wrap && pending) begin
          active_fword <= shadow_fword;
          active_poff  <= shadow_poff;
          pending      <= 1'b0;
        end else if (handshake) begin
          shadow_fword <= cfg_fword;
          shadow_poff  <= cfg_poff;
          pending      <= 1'b1;
        end
      end

      if (state_next == FLUSH) pending <= 1'b0;
    end
  end

  wave_seq_pipe #(
    .LATENCY (ROM_LATENCY)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (issue),
    .in_period  (issue && (acc == '0)),
    .out_valid  (dac_valid),
    .out_period (period_start)
  );

  assign dac_data = dac_valid ? rom_rddata : MID_SAMPLE;
endmodule
